// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg
//   Shared definitions for the immediate generator pipeline.
//   IMM_TYPE_W : width of the immediate-type selector
//   imm_type_e : immediate format selector; codes 0..3 keep the legacy
//                2-bit encoding, 4..6 add U/shamt/zimm, 7 is reserved/illegal
package imm_gen_pkg;

  localparam int IMM_TYPE_W = 3;

  typedef enum logic [IMM_TYPE_W-1:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_J     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_SHAMT = 3'd5,
    IMM_ZIMM  = 3'd6,
    IMM_ILL   = 3'd7
  } imm_type_e;

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// imm_extract
//   Purely combinational immediate extraction and sign/zero extension.
//   inst     : raw 32-bit instruction word (bits [6:0] are not used)
//   imm_type : immediate format selector
//   imm      : XLEN-bit extended immediate (0 for an illegal type)
//   err      : high when imm_type is the reserved/illegal code
module imm_extract
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  // Opcode bits never contribute to any immediate format.
  logic unused_opcode_s;
  assign unused_opcode_s = ^inst[6:0];

  // Format decode; every replication count stays >= 1 for XLEN 32 and 64.
  always_comb begin
    imm = '0;
    err = 1'b0;
    case (imm_type)
      IMM_I:     imm = {{(XLEN-11){inst[31]}}, inst[30:20]};
      IMM_S:     imm = {{(XLEN-11){inst[31]}}, inst[30:25], inst[11:7]};
      IMM_J:     imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_B:     imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      // U-type: bit 31 is the sign for XLEN=64 as well.
      IMM_U:     imm = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
      IMM_SHAMT: imm = {{(XLEN-5){1'b0}}, inst[24:20]};
      IMM_ZIMM:  imm = {{(XLEN-5){1'b0}}, inst[19:15]};
      IMM_ILL:   err = 1'b1;
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Flow-controlled immediate generator: extracts the immediate on push and
//   queues {imm, tag, err} in a DEPTH-entry FIFO read out in strict order.
//   clk, rst_n         : clock (rising edge), async active-low reset
//   in_val/in_rdy      : request handshake; in_rdy depends on occupancy only
//   in_inst/type/tag   : instruction word, immediate type, opaque tag
//   out_val/out_rdy    : result handshake; out_val = buffer not empty
//   out_imm/tag/err    : head entry, driven straight from storage registers
//   out_count          : current occupancy
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_val,
  output logic                       in_rdy,
  input  logic [31:0]                in_inst,
  input  logic [IMM_TYPE_W-1:0]      in_type,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [XLEN-1:0]            out_imm,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_err,
  output logic [$clog2(DEPTH+1)-1:0] out_count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0]  ext_imm_s;
  logic             ext_err_s;
  logic             push_s;
  logic             pop_s;

  logic [XLEN-1:0]  imm_mem_r [DEPTH];
  logic [TAG_W-1:0] tag_mem_r [DEPTH];
  logic             err_mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH-1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  imm_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .inst     (in_inst),
    .imm_type (imm_type_e'(in_type)),
    .imm      (ext_imm_s),
    .err      (ext_err_s)
  );

  // in_rdy deliberately ignores out_rdy: a full buffer refuses a push even
  // while it is being popped, which keeps out_rdy off the input timing path.
  assign in_rdy    = (count_r < CNT_W'(DEPTH));
  assign out_val   = (count_r != '0);
  assign push_s    = in_val && in_rdy;
  assign pop_s     = out_val && out_rdy;
  assign out_imm   = imm_mem_r[rd_ptr_r];
  assign out_tag   = tag_mem_r[rd_ptr_r];
  assign out_err   = err_mem_r[rd_ptr_r];
  assign out_count = count_r;

  // Entry storage; cleared on reset so an empty buffer presents zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        imm_mem_r[i] <= '0;
        tag_mem_r[i] <= '0;
        err_mem_r[i] <= 1'b0;
      end
    end else if (push_s) begin
      imm_mem_r[wr_ptr_r] <= ext_imm_s;
      tag_mem_r[wr_ptr_r] <= in_tag;
      err_mem_r[wr_ptr_r] <= ext_err_s;
    end
  end

  // Read/write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
    end
  end

  // Occupancy: distinguishes full from empty when the pointers are equal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe
//   Drives an XLEN=32 and an XLEN=64 instance with identical stimulus and
//   checks both against a queue-based reference model every cycle.
module tb_imm_gen_pipe;

  localparam int DEPTH = 2;
  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_val;
  logic [31:0]       in_inst;
  logic [2:0]        in_type;
  logic [TAG_W-1:0]  in_tag;
  logic              out_rdy;

  logic              rdy_a, val_a, err_a;
  logic [31:0]       imm_a;
  logic [TAG_W-1:0]  tag_a;
  logic [1:0]        cnt_a;
  logic              rdy_b, val_b, err_b;
  logic [63:0]       imm_b;
  logic [TAG_W-1:0]  tag_b;
  logic [1:0]        cnt_b;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(rdy_a),
    .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag),
    .out_val(val_a), .out_rdy(out_rdy), .out_imm(imm_a), .out_tag(tag_a),
    .out_err(err_a), .out_count(cnt_a)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(rdy_b),
    .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag),
    .out_val(val_b), .out_rdy(out_rdy), .out_imm(imm_b), .out_tag(tag_b),
    .out_err(err_b), .out_count(cnt_b)
  );

  typedef struct {
    logic [31:0]      e32;
    logic [63:0]      e64;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference immediate: assemble the field value numerically, then apply
  // two's-complement sign extension by subtraction.
  function automatic logic [63:0] ref_imm(input logic [31:0] inst, input int ty);
    longint unsigned u;
    longint unsigned v;
    longint          s;
    int              w;
    bit              sgn;
    u   = 64'(inst);
    sgn = 1'b1;
    case (ty)
      0: begin v = u >> 20; w = 12; end
      1: begin v = ((u >> 25) << 5) | ((u >> 7) & 64'd31); w = 12; end
      2: begin
        v = (((u >> 31) & 64'd1) << 20) | (((u >> 12) & 64'd255) << 12) |
            (((u >> 20) & 64'd1) << 11) | (((u >> 21) & 64'd1023) << 1);
        w = 21;
      end
      3: begin
        v = (((u >> 31) & 64'd1) << 12) | (((u >> 7) & 64'd1) << 11) |
            (((u >> 25) & 64'd63) << 5) | (((u >> 8) & 64'd15) << 1);
        w = 13;
      end
      4: begin v = u & 64'hFFFF_F000; w = 32; end
      5: begin v = (u >> 20) & 64'd31; w = 5; sgn = 1'b0; end
      6: begin v = (u >> 15) & 64'd31; w = 5; sgn = 1'b0; end
      default: begin v = 64'd0; w = 1; sgn = 1'b0; end
    endcase
    if (sgn && (((v >> (w - 1)) & 64'd1) != 64'd0)) begin
      s = longint'(v) - (longint'(1) << w);
    end else begin
      s = longint'(v);
    end
    return 64'(s);
  endfunction

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = q.size();
    check_eq("in_rdy32",  64'(rdy_a), 64'(n < DEPTH));
    check_eq("in_rdy64",  64'(rdy_b), 64'(n < DEPTH));
    check_eq("out_val32", 64'(val_a), 64'(n > 0));
    check_eq("out_val64", 64'(val_b), 64'(n > 0));
    check_eq("count32",   64'(cnt_a), 64'(n));
    check_eq("count64",   64'(cnt_b), 64'(n));
    if (n > 0) begin
      check_eq("imm32", 64'(imm_a), 64'(q[0].e32));
      check_eq("imm64", imm_b,      q[0].e64);
      check_eq("tag32", 64'(tag_a), 64'(q[0].tag));
      check_eq("tag64", 64'(tag_b), 64'(q[0].tag));
      check_eq("err32", 64'(err_a), 64'(q[0].err));
      check_eq("err64", 64'(err_b), 64'(q[0].err));
    end
  endtask

  // One cycle: check outputs at the falling edge, drive new inputs, then
  // update the model with whatever handshakes complete at the rising edge.
  // use_x selects fixed expected values instead of the reference function.
  task automatic step(input bit v, input logic [31:0] inst, input logic [2:0] ty,
                      input logic [TAG_W-1:0] tag, input bit ordy,
                      input bit use_x, input logic [31:0] x32, input logic [63:0] x64);
    exp_t e;
    bit   push;
    bit   pop;
    @(negedge clk);
    check_outputs();
    in_val  = v;
    in_inst = inst;
    in_type = ty;
    in_tag  = tag;
    out_rdy = ordy;
    push    = v && (q.size() < DEPTH);
    pop     = ordy && (q.size() > 0);
    e.tag   = tag;
    e.err   = (ty == 3'd7);
    if (use_x) begin
      e.e32 = x32;
      e.e64 = x64;
    end else begin
      e.e64 = ref_imm(inst, int'(ty));
      e.e32 = e.e64[31:0];
    end
    @(posedge clk);
    if (pop)  q.delete(0);
    if (push) q.push_back(e);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 32'h0, 3'd0, 4'h0, ordy, 1'b0, 32'h0, 64'h0);
  endtask

  initial begin
    // Reset held with a valid request present: nothing may be accepted.
    rst_n   = 1'b0;
    in_val  = 1'b1;
    in_inst = 32'hFFF0_0093;
    in_type = 3'd0;
    in_tag  = 4'h1;
    out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_in_rdy32",  64'(rdy_a), 64'd1);
    check_eq("rst_in_rdy64",  64'(rdy_b), 64'd1);
    check_eq("rst_out_val32", 64'(val_a), 64'd0);
    check_eq("rst_out_val64", 64'(val_b), 64'd0);
    check_eq("rst_count32",   64'(cnt_a), 64'd0);
    check_eq("rst_imm32",     64'(imm_a), 64'd0);
    check_eq("rst_imm64",     imm_b,      64'd0);
    check_eq("rst_tag32",     64'(tag_a), 64'd0);
    check_eq("rst_err32",     64'(err_a), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    in_val = 1'b0;

    // ADDI -1, result visible the cycle after the push.
    step(1'b1, 32'hFFF0_0093, 3'd0, 4'h1, 1'b1, 1'b1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(1'b1);

    // Back-to-back with the consumer always ready.
    step(1'b1, 32'h0011_2423, 3'd1, 4'h2, 1'b1, 1'b1, 32'h0000_0008, 64'h8);
    step(1'b1, 32'hFFDF_F06F, 3'd2, 4'h3, 1'b1, 1'b1, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, 32'hFE20_9CE3, 3'd3, 4'h4, 1'b1, 1'b1, 32'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8);
    step(1'b1, 32'h1234_50B7, 3'd4, 4'h5, 1'b1, 1'b1, 32'h1234_5000, 64'h0000_0000_1234_5000);
    idle(1'b1);

    // Stalled consumer: third request must wait, including during the first pop.
    step(1'b1, 32'h0011_2423, 3'd1, 4'hA, 1'b0, 1'b0, 32'h0, 64'h0);
    step(1'b1, 32'hFE20_9CE3, 3'd3, 4'hB, 1'b0, 1'b0, 32'h0, 64'h0);
    step(1'b1, 32'hFFDF_F06F, 3'd2, 4'hC, 1'b0, 1'b0, 32'h0, 64'h0);
    step(1'b1, 32'hFFDF_F06F, 3'd2, 4'hC, 1'b0, 1'b0, 32'h0, 64'h0);
    step(1'b1, 32'hFFDF_F06F, 3'd2, 4'hC, 1'b1, 1'b0, 32'h0, 64'h0);
    step(1'b1, 32'hFFDF_F06F, 3'd2, 4'hC, 1'b1, 1'b0, 32'h0, 64'h0);
    repeat (3) idle(1'b1);

    // Illegal type, shamt, zimm.
    step(1'b1, 32'hDEAD_BEEF, 3'd7, 4'h5, 1'b1, 1'b1, 32'h0, 64'h0);
    step(1'b1, 32'h4051_5093, 3'd5, 4'h6, 1'b1, 1'b1, 32'h5, 64'h5);
    step(1'b1, 32'h3400_F073, 3'd6, 4'h7, 1'b1, 1'b1, 32'h1, 64'h1);
    // U-type sign extension at 64 bits, positive ADDI.
    step(1'b1, 32'h8000_00B7, 3'd4, 4'h8, 1'b1, 1'b1, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000);
    step(1'b1, 32'h7FF0_0093, 3'd0, 4'h9, 1'b1, 1'b1, 32'h7FF, 64'h7FF);
    idle(1'b1);

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 9) < 7), $urandom(), 3'($urandom_range(0, 7)),
           4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 6), 1'b0, 32'h0, 64'h0);
    end
    repeat (3) idle(1'b1);

    // Reset mid-stream with a full buffer.
    step(1'b1, 32'hFFF0_0093, 3'd0, 4'hD, 1'b0, 1'b0, 32'h0, 64'h0);
    step(1'b1, 32'h0011_2423, 3'd1, 4'hE, 1'b0, 1'b0, 32'h0, 64'h0);
    in_val = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_val32", 64'(val_a), 64'd0);
    check_eq("midrst_out_val64", 64'(val_b), 64'd0);
    check_eq("midrst_count32",   64'(cnt_a), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h1234_50B7, 3'd4, 4'h3, 1'b1, 1'b1, 32'h1234_5000, 64'h0000_0000_1234_5000);
    idle(1'b1);
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
